// File: rtl/mult_div_unit_pkg.sv
// Shared types and constants for the execute-stage multiply/divide unit.
package mult_div_unit_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [2:0] {
    OP_NOP,
    OP_ADDU,
    OP_SUBU,
    OP_MULT,
    OP_MULTU,
    OP_DIV,
    OP_DIVU
  } decoded_op_t;

  typedef enum logic [2:0] {
    MDU_IDLE,
    MDU_MUL,
    MDU_DIV,
    MDU_FIX,
    MDU_DONE
  } mdu_state_t;

  localparam int DIV_ITERS = 32;
  localparam int CNT_W     = $clog2(DIV_ITERS);

  function automatic word_t cond_neg(input logic neg, input word_t v);
    return neg ? -v : v;
  endfunction

endpackage

// File: rtl/mult_div_unit_div_iter.sv
// One radix-2 restoring division step: shift in the next dividend bit, subtract if it fits.
module div_iter
  import mult_div_unit_pkg::*;
(
  input  logic [32:0] rem_i,
  input  word_t       quo_i,
  input  word_t       divisor_i,
  output logic [32:0] rem_o,
  output word_t       quo_o
);

  logic [33:0] trial;
  logic [33:0] diff;
  logic        fits;

  // The quotient register still holds the unconsumed dividend bits at its MSB end.
  assign trial = {rem_i, quo_i[31]};
  assign diff  = trial - {2'b00, divisor_i};
  assign fits  = ~diff[33];

  assign rem_o = fits ? diff[32:0] : trial[32:0];
  assign quo_o = {quo_i[30:0], fits};

endmodule

// File: rtl/mult_div_unit.sv
// Shared MULT/MULTU/DIV/DIVU responder: two-cycle multiply, 32-step restoring divide,
// result held on hi/lo with a level ok until the next start or a flush.
module mult_div_unit
  import mult_div_unit_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        flushE,
  input  logic        first_cycleE,
  input  logic        en,
  input  decoded_op_t op,
  input  word_t       srca,
  input  word_t       srcb,
  output word_t       hi,
  output word_t       lo,
  output logic        ok
);

  mdu_state_t       state_q;
  word_t            a_q;
  word_t            b_q;
  logic [32:0]      rem_q;
  logic [CNT_W-1:0] cnt_q;
  logic             mul_signed_q;
  logic             qneg_q;
  logic             rneg_q;

  logic             start;
  logic             div_signed;
  logic             div_by_zero;
  logic             neg_a;
  logic             neg_b;
  logic signed [32:0] mul_a;
  logic signed [32:0] mul_b;
  logic signed [63:0] product;
  logic [32:0]      rem_d;
  word_t            quo_d;

  assign start       = en & first_cycleE & ~flushE;
  assign div_signed  = (op == OP_DIV);
  assign div_by_zero = (srcb == '0);

  // Dividing by zero skips the magnitude conversion, so the raw dividend shifts out as the remainder.
  assign neg_a = div_signed & ~div_by_zero & srca[31];
  assign neg_b = div_signed & ~div_by_zero & srcb[31];

  assign mul_a   = {mul_signed_q & a_q[31], a_q};
  assign mul_b   = {mul_signed_q & b_q[31], b_q};
  assign product = 64'(mul_a) * 64'(mul_b);

  div_iter u_div_iter (
    .rem_i     (rem_q),
    .quo_i     (a_q),
    .divisor_i (b_q),
    .rem_o     (rem_d),
    .quo_o     (quo_d)
  );

  // NOTE: non-blocking assignments only, so every branch reads pre-edge register values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= MDU_IDLE;
      hi           <= '0;
      lo           <= '0;
      ok           <= 1'b0;
      cnt_q        <= '0;
      a_q          <= '0;
      b_q          <= '0;
      rem_q        <= '0;
      mul_signed_q <= 1'b0;
      qneg_q       <= 1'b0;
      rneg_q       <= 1'b0;
    end else if (flushE) begin
      state_q <= MDU_IDLE;
      ok      <= 1'b0;
    end else if (start) begin
      ok <= 1'b0;
      case (op)
        OP_MULT, OP_MULTU: begin
          a_q          <= srca;
          b_q          <= srcb;
          mul_signed_q <= (op == OP_MULT);
          state_q      <= MDU_MUL;
        end
        OP_DIV, OP_DIVU: begin
          a_q     <= cond_neg(neg_a, srca);
          b_q     <= cond_neg(neg_b, srcb);
          rem_q   <= '0;
          qneg_q  <= neg_a ^ neg_b;
          rneg_q  <= neg_a;
          cnt_q   <= CNT_W'(DIV_ITERS - 1);
          state_q <= MDU_DIV;
        end
        default: begin
          hi      <= '0;
          lo      <= '0;
          ok      <= 1'b1;
          state_q <= MDU_DONE;
        end
      endcase
    end else begin
      case (state_q)
        MDU_MUL: begin
          {hi, lo} <= product;
          ok       <= 1'b1;
          state_q  <= MDU_DONE;
        end
        MDU_DIV: begin
          rem_q <= rem_d;
          a_q   <= quo_d;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == '0) state_q <= MDU_FIX;
        end
        MDU_FIX: begin
          lo      <= cond_neg(qneg_q, a_q);
          hi      <= cond_neg(rneg_q, rem_q[31:0]);
          ok      <= 1'b1;
          state_q <= MDU_DONE;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Randomized and directed bench for mult_div_unit against an arithmetic reference model.
module tb_mult_div_unit;
  import mult_div_unit_pkg::*;

  logic        clk;
  logic        reset;
  logic        flushE;
  logic        first_cycleE;
  logic        en;
  decoded_op_t op;
  word_t       srca;
  word_t       srcb;
  word_t       hi;
  word_t       lo;
  logic        ok;

  int    tests_run    = 0;
  int    tests_failed = 0;
  word_t exp_hi;
  word_t exp_lo;

  mult_div_unit dut (
    .clk          (clk),
    .reset        (reset),
    .flushE       (flushE),
    .first_cycleE (first_cycleE),
    .en           (en),
    .op           (op),
    .srca         (srca),
    .srcb         (srcb),
    .hi           (hi),
    .lo           (lo),
    .ok           (ok)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic; latency in cycles from the start cycle to ok.
  task automatic model(input decoded_op_t o, input word_t a, input word_t b,
                       output word_t ehi, output word_t elo, output int lat);
    logic [63:0] p;
    longint      sa;
    longint      sb;
    longint      q;
    longint      r;
    case (o)
      OP_MULT: begin
        p   = longint'($signed(a)) * longint'($signed(b));
        ehi = p[63:32];
        elo = p[31:0];
        lat = 2;
      end
      OP_MULTU: begin
        p   = {32'b0, a} * {32'b0, b};
        ehi = p[63:32];
        elo = p[31:0];
        lat = 2;
      end
      OP_DIV, OP_DIVU: begin
        lat = 34;
        if (b == 0) begin
          elo = 32'hFFFF_FFFF;
          ehi = a;
        end else begin
          sa  = (o == OP_DIV) ? longint'($signed(a)) : longint'({32'b0, a});
          sb  = (o == OP_DIV) ? longint'($signed(b)) : longint'({32'b0, b});
          q   = sa / sb;
          r   = sa % sb;
          elo = q[31:0];
          ehi = r[31:0];
        end
      end
      default: begin
        ehi = '0;
        elo = '0;
        lat = 1;
      end
    endcase
  endtask

  // Called just after a falling edge; returns just after the falling edge where ok is seen.
  task automatic run_op(input decoded_op_t o, input word_t a, input word_t b, input string tag);
    word_t ehi;
    word_t elo;
    int    lat;
    int    n;
    model(o, a, b, ehi, elo, lat);
    en           = 1'b1;
    first_cycleE = 1'b1;
    op           = o;
    srca         = a;
    srcb         = b;
    @(negedge clk);
    first_cycleE = 1'b0;
    n = 1;
    if (lat > 1) check({tag, "_ok_clr"}, 64'(ok), 64'(0));
    while (!ok && n < 60) begin
      check({tag, "_mid"}, {hi, lo}, {exp_hi, exp_lo});
      @(negedge clk);
      n++;
    end
    check({tag, "_lat"}, 64'(n), 64'(lat));
    check({tag, "_hi"}, 64'(hi), 64'(ehi));
    check({tag, "_lo"}, 64'(lo), 64'(elo));
    exp_hi = ehi;
    exp_lo = elo;
  endtask

  task automatic hold(input int n, input logic ok_exp, input string tag);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check({tag, "_ok"}, 64'(ok), 64'(ok_exp));
      check({tag, "_hilo"}, {hi, lo}, {exp_hi, exp_lo});
    end
  endtask

  function automatic word_t rand_word();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return word_t'($urandom_range(1, 20));
      default: return word_t'($urandom);
    endcase
  endfunction

  initial begin
    decoded_op_t ro;
    reset        = 1'b1;
    flushE       = 1'b0;
    first_cycleE = 1'b0;
    en           = 1'b0;
    op           = OP_NOP;
    srca         = '0;
    srcb         = '0;
    exp_hi       = '0;
    exp_lo       = '0;
    repeat (2) @(negedge clk);
    check("reset_hilo", {hi, lo}, 64'(0));
    check("reset_ok", 64'(ok), 64'(0));
    reset = 1'b0;
    @(negedge clk);

    run_op(OP_MULT,  32'hFFFF_FFFD, 32'd5, "mult_neg");
    check("mult_neg_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF1);
    run_op(OP_MULTU, 32'hFFFF_FFFD, 32'd5, "multu");
    check("multu_const", {hi, lo}, 64'h0000_0004_FFFF_FFF1);
    run_op(OP_DIVU, 32'd100, 32'd7, "divu_100_7");
    run_op(OP_DIV,  32'hFFFF_FFF9, 32'd2, "div_neg7_2");
    run_op(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    check("div_ovf_const", {hi, lo}, 64'h0000_0000_8000_0000);
    run_op(OP_DIVU, 32'h1234_5678, 32'd0, "divu_by0");
    run_op(OP_DIV,  32'h8765_4321, 32'd0, "div_by0");
    run_op(OP_NOP,  32'd5, 32'd6, "null_op");

    // Flush in cycle 10 of a divide: the divide never completes.
    en = 1'b1; first_cycleE = 1'b1; op = OP_DIV; srca = 32'd1000; srcb = 32'd7;
    @(negedge clk);
    first_cycleE = 1'b0;
    repeat (9) @(negedge clk);
    flushE = 1'b1;
    @(negedge clk);
    flushE = 1'b0;
    hold(40, 1'b0, "flush");
    run_op(OP_MULT, 32'd6, 32'd7, "mult_after_flush");

    // Sit in DONE with en high, then a back-to-back divide.
    hold(5, 1'b1, "done_hold");
    run_op(OP_DIVU, 32'd9, 32'd3, "divu_9_3");

    en = 1'b0;
    hold(3, 1'b1, "en_drop");

    // Asynchronous reset in cycle 15 of a divide.
    en = 1'b1; first_cycleE = 1'b1; op = OP_DIV; srca = 32'hDEAD_BEEF; srcb = 32'h0000_0123;
    @(negedge clk);
    first_cycleE = 1'b0;
    repeat (14) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("async_rst_hilo", {hi, lo}, 64'(0));
    check("async_rst_ok", 64'(ok), 64'(0));
    exp_hi = '0;
    exp_lo = '0;
    @(negedge clk);
    reset = 1'b0;
    hold(40, 1'b0, "post_reset");

    // Flush together with a start: nothing begins.
    run_op(OP_MULTU, 32'd123, 32'd456, "pre_flush_start");
    first_cycleE = 1'b1; flushE = 1'b1; op = OP_DIVU; srca = 32'd50; srcb = 32'd5;
    @(negedge clk);
    first_cycleE = 1'b0;
    flushE = 1'b0;
    hold(40, 1'b0, "flush_start");

    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 4))
        0:       ro = OP_MULT;
        1:       ro = OP_MULTU;
        2:       ro = OP_DIV;
        3:       ro = OP_DIVU;
        default: ro = OP_NOP;
      endcase
      run_op(ro, rand_word(), rand_word(), $sformatf("rnd%0d_%s", i, ro.name()));
      if ($urandom_range(0, 3) == 0) hold($urandom_range(1, 3), 1'b1, "rnd_gap");
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
